// File: rtl/vendo_pkg.sv
// Shared types and helpers for the vending dispense scheduler.
package vendo_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    GAP  = 2'd2
  } state_e;

  localparam logic [1:0] CH_A   = 2'd0;
  localparam logic [1:0] CH_B   = 2'd1;
  localparam logic [1:0] CH_CHG = 2'd2;

  // Successor in the fixed ring A -> B -> CHG -> A.
  function automatic logic [1:0] ch_after(input logic [1:0] ch);
    return (ch == CH_CHG) ? CH_A : ch + 2'd1;
  endfunction

  // First pending channel strictly after rr, wrapping back to rr itself last.
  // The caller only uses the result when at least one channel is pending.
  function automatic logic [1:0] rr_pick(input logic [1:0] rr, input logic [2:0] pend);
    logic [1:0] c1;
    logic [1:0] c2;
    c1 = ch_after(rr);
    c2 = ch_after(c1);
    if (pend[c1])      return c1;
    else if (pend[c2]) return c2;
    else               return rr;
  endfunction

endpackage

// File: rtl/vendo_pend_ctr.sv
// Saturating pending-request counter for one dispense channel.
module vendo_pend_ctr #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             sat
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: simultaneous inc and dec cancel; hold at the rails.
  always_comb begin
    cnt_d = cnt_q;
    if (inc && !dec) begin
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_ONE;
    end else if (dec && !inc) begin
      if (cnt_q != '0) cnt_d = cnt_q - CNT_ONE;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;
  assign sat = (cnt_q == CNT_MAX);

endmodule

// File: rtl/vendo_dispense_sched.sv
// Round-robin scheduler that serialises dispense requests onto one actuator.
//
//  state | meaning
//  ------+-----------------------------------------------------------
//  IDLE  | no actuator on; grant next pending channel after rr pointer
//  ON    | granted actuator driven high for ON_CYCLES cycles
//  GAP   | all actuators low for GAP_CYCLES recovery cycles
module vendo_dispense_sched
  import vendo_pkg::*;
#(
  parameter int ON_CYCLES  = 50,
  parameter int GAP_CYCLES = 10,
  parameter int CNT_W      = 3
) (
  input  logic clk,
  input  logic nrst,
  input  logic req_A,
  input  logic req_B,
  input  logic req_chg,
  input  logic err_clr,
  output logic act_A,
  output logic act_B,
  output logic act_chg,
  output logic busy,
  output logic pend_any,
  output logic ovf_err
);

  localparam int TMR_MAX = (ON_CYCLES > GAP_CYCLES) ? ON_CYCLES : GAP_CYCLES;
  localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
  localparam logic [TMR_W-1:0] T_ON  = TMR_W'(ON_CYCLES - 1);
  localparam logic [TMR_W-1:0] T_GAP = TMR_W'(GAP_CYCLES - 1);
  localparam logic [TMR_W-1:0] T_ONE = 1;

  state_e           state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [1:0]       rr_q, rr_d;
  logic [2:0]       act_q, act_d;
  logic             ovf_q, ovf_d;

  logic [2:0]       req_v;
  logic [2:0]       dec_v;
  logic [2:0]       sat_v;
  logic [2:0]       pend_v;
  logic [1:0]       grant_ch;
  logic [CNT_W-1:0] cnt_a, cnt_b, cnt_chg;

  assign req_v = {req_chg, req_B, req_A};

  vendo_pend_ctr #(.CNT_W(CNT_W)) u_ctr_a (
    .clk(clk), .nrst(nrst), .inc(req_A), .dec(dec_v[CH_A]),
    .cnt(cnt_a), .sat(sat_v[CH_A])
  );

  vendo_pend_ctr #(.CNT_W(CNT_W)) u_ctr_b (
    .clk(clk), .nrst(nrst), .inc(req_B), .dec(dec_v[CH_B]),
    .cnt(cnt_b), .sat(sat_v[CH_B])
  );

  vendo_pend_ctr #(.CNT_W(CNT_W)) u_ctr_chg (
    .clk(clk), .nrst(nrst), .inc(req_chg), .dec(dec_v[CH_CHG]),
    .cnt(cnt_chg), .sat(sat_v[CH_CHG])
  );

  assign pend_v   = {(cnt_chg != '0), (cnt_b != '0), (cnt_a != '0)};
  assign grant_ch = rr_pick(rr_q, pend_v);

  // Next-state, timer, pointer, actuator and error-flag logic.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    rr_d    = rr_q;
    act_d   = act_q;
    dec_v   = '0;
    ovf_d   = ovf_q;

    case (state_q)
      IDLE: begin
        act_d = '0;
        if (|pend_v) begin
          dec_v[grant_ch] = 1'b1;
          rr_d            = grant_ch;
          timer_d         = T_ON;
          act_d           = 3'b001 << grant_ch;
          state_d         = ON;
        end
      end
      ON: begin
        if (timer_q == '0) begin
          timer_d = T_GAP;
          act_d   = '0;
          state_d = GAP;
        end else begin
          timer_d = timer_q - T_ONE;
        end
      end
      GAP: begin
        act_d = '0;
        if (timer_q == '0) state_d = IDLE;
        else               timer_d = timer_q - T_ONE;
      end
      default: begin
        act_d   = '0;
        timer_d = '0;
        state_d = IDLE;
      end
    endcase

    // A request against a full counter is lost unless a grant frees a slot.
    if (err_clr) ovf_d = 1'b0;
    if (|(req_v & sat_v & ~dec_v)) ovf_d = 1'b1;
  end

  // Scheduler state and registered outputs.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
      timer_q <= '0;
      rr_q    <= CH_CHG;
      act_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      rr_q    <= rr_d;
      act_q   <= act_d;
      ovf_q   <= ovf_d;
    end
  end

  assign act_A    = act_q[CH_A];
  assign act_B    = act_q[CH_B];
  assign act_chg  = act_q[CH_CHG];
  assign busy     = (state_q != IDLE);
  assign pend_any = |pend_v;
  assign ovf_err  = ovf_q;

endmodule

// File: tb/tb_vendo_dispense_sched.sv
// Directed bench for vendo_dispense_sched with ON=3, GAP=2, CNT_W=2.
module tb_vendo_dispense_sched;

  logic clk = 1'b0;
  logic nrst;
  logic req_A, req_B, req_chg, err_clr;
  logic act_A, act_B, act_chg, busy, pend_any, ovf_err;

  int vec_cnt = 0;
  int err_cnt = 0;

  always #10 clk = ~clk;

  vendo_dispense_sched #(
    .ON_CYCLES(3), .GAP_CYCLES(2), .CNT_W(2)
  ) u_dut (
    .clk(clk), .nrst(nrst),
    .req_A(req_A), .req_B(req_B), .req_chg(req_chg), .err_clr(err_clr),
    .act_A(act_A), .act_B(act_B), .act_chg(act_chg),
    .busy(busy), .pend_any(pend_any), .ovf_err(ovf_err)
  );

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    nrst = 1'b0; req_A = 1'b0; req_B = 1'b0; req_chg = 1'b0; err_clr = 1'b0;
    step(2);
    nrst = 1'b1;
    step(1);
  endtask

  // Hold the given requests across exactly one rising edge.
  task automatic pulse(input logic a, input logic b, input logic c);
    req_A = a; req_B = b; req_chg = c;
    step(1);
    req_A = 1'b0; req_B = 1'b0; req_chg = 1'b0;
  endtask

  // Bit i of each mask is the expected level after the i-th following edge.
  task automatic run_trace(input string name, input int n, input logic [31:0] ma,
                           input logic [31:0] mb, input logic [31:0] mc, input logic [31:0] mbusy);
    int on_cnt;
    for (int i = 0; i < n; i++) begin
      step(1);
      chk_eq($sformatf("%s.act_A[%0d]", name, i), {31'b0, act_A}, {31'b0, ma[i]});
      chk_eq($sformatf("%s.act_B[%0d]", name, i), {31'b0, act_B}, {31'b0, mb[i]});
      chk_eq($sformatf("%s.act_chg[%0d]", name, i), {31'b0, act_chg}, {31'b0, mc[i]});
      chk_eq($sformatf("%s.busy[%0d]", name, i), {31'b0, busy}, {31'b0, mbusy[i]});
      on_cnt = int'(act_A) + int'(act_B) + int'(act_chg);
      chk_eq($sformatf("%s.excl[%0d]", name, i), {31'b0, (on_cnt > 1)}, 32'd0);
    end
  endtask

  initial begin
    int nb;
    int n_on;
    logic prev_b;

    // Reset state
    do_reset();
    chk_eq("rst.act", {29'b0, act_A, act_B, act_chg}, 32'd0);
    chk_eq("rst.busy", {31'b0, busy}, 32'd0);
    chk_eq("rst.pend", {31'b0, pend_any}, 32'd0);
    chk_eq("rst.ovf", {31'b0, ovf_err}, 32'd0);

    // 1: single request A
    pulse(1'b1, 1'b0, 1'b0);
    chk_eq("t1.pend_after_req", {31'b0, pend_any}, 32'd1);
    chk_eq("t1.act_not_yet", {31'b0, act_A}, 32'd0);
    run_trace("t1", 6, 32'h7, 32'h0, 32'h0, 32'h1F);
    chk_eq("t1.pend_end", {31'b0, pend_any}, 32'd0);
    chk_eq("t1.cnt_a_end", 32'(u_dut.u_ctr_a.cnt), 32'd0);

    // 2: all three in one cycle, order A, B, CHG, 6 cycles apart
    do_reset();
    pulse(1'b1, 1'b1, 1'b1);
    run_trace("t2", 18, 32'h7, 32'h1C0, 32'h7000, 32'h1F7DF);
    chk_eq("t2.pend_end", {31'b0, pend_any}, 32'd0);

    // 3: round robin, B served before the re-requested A
    do_reset();
    pulse(1'b1, 1'b0, 1'b0);
    step(1);
    chk_eq("t3.a_granted", {31'b0, act_A}, 32'd1);
    pulse(1'b1, 1'b1, 1'b0);
    run_trace("t3", 16, 32'h1C01, 32'h70, 32'h0, 32'h7DF7);

    // 4: saturation and overflow on B
    do_reset();
    pulse(1'b1, 1'b0, 1'b0);
    step(1);
    chk_eq("t4.busy", {31'b0, busy}, 32'd1);
    chk_eq("t4.ovf_before", {31'b0, ovf_err}, 32'd0);
    for (int i = 0; i < 4; i++) pulse(1'b0, 1'b1, 1'b0);
    chk_eq("t4.cnt_b_sat", 32'(u_dut.u_ctr_b.cnt), 32'd3);
    chk_eq("t4.ovf_set", {31'b0, ovf_err}, 32'd1);
    nb = 0;
    prev_b = act_B;
    for (int i = 0; i < 26; i++) begin
      step(1);
      if (act_B && !prev_b) nb++;
      prev_b = act_B;
    end
    chk_eq("t4.b_dispenses", 32'(nb), 32'd3);
    chk_eq("t4.ovf_sticky", {31'b0, ovf_err}, 32'd1);
    chk_eq("t4.pend_end", {31'b0, pend_any}, 32'd0);
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
    chk_eq("t4.ovf_cleared", {31'b0, ovf_err}, 32'd0);

    // 5: request on the grant cycle keeps the count at 1
    do_reset();
    pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b1, 1'b0, 1'b0);
    chk_eq("t5.act_A", {31'b0, act_A}, 32'd1);
    chk_eq("t5.cnt_a", 32'(u_dut.u_ctr_a.cnt), 32'd1);
    chk_eq("t5.pend", {31'b0, pend_any}, 32'd1);
    run_trace("t5", 11, 32'hE3, 32'h0, 32'h0, 32'h3EF);
    chk_eq("t5.pend_end", {31'b0, pend_any}, 32'd0);

    // 6: reset during act_B with A pending
    do_reset();
    pulse(1'b0, 1'b1, 1'b0);
    step(1);
    pulse(1'b1, 1'b0, 1'b0);
    chk_eq("t6.act_B_mid", {31'b0, act_B}, 32'd1);
    chk_eq("t6.pend_mid", {31'b0, pend_any}, 32'd1);
    #3;
    nrst = 1'b0;
    #1;
    chk_eq("t6.rst_act", {29'b0, act_A, act_B, act_chg}, 32'd0);
    chk_eq("t6.rst_busy", {31'b0, busy}, 32'd0);
    chk_eq("t6.rst_pend", {31'b0, pend_any}, 32'd0);
    chk_eq("t6.rst_cnt_a", 32'(u_dut.u_ctr_a.cnt), 32'd0);
    step(1);
    nrst = 1'b1;
    n_on = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (act_A || act_B || act_chg || busy) n_on++;
    end
    chk_eq("t6.no_dispense", 32'(n_on), 32'd0);
    chk_eq("t6.pend_end", {31'b0, pend_any}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
